draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter: NUM_CLIENTS, default 4, number of drawing clients (ball, ball, paddle bottom, paddle top).
REQ-002 Parameter: TIMEOUT, default 26'd4000000, maximum cycles one client may hold the grant.
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  game running; low stops new grants.
REQ-006 Port: client_en  input  NUM_CLIENTS  per-client participation mask.
REQ-007 Port: client_done  input  NUM_CLIENTS  per-client done level (high while the client sits in its post-draw hold).
REQ-008 Port: client_plot  input  NUM_CLIENTS  per-client writeEn.
REQ-009 Port: client_x  input  8*NUM_CLIENTS  packed x coordinates, client i at [8i+7:8i].
REQ-010 Port: client_y  input  7*NUM_CLIENTS  packed y coordinates.
REQ-011 Port: client_color  input  3*NUM_CLIENTS  packed colours.
REQ-012 Port: client_go  output  NUM_CLIENTS  one-hot go to the granted client.
REQ-013 Port: vga_x / vga_y / vga_color / vga_plot  output  8/7/3/1  muxed pixel write to the VGA adapter.
REQ-014 Port: grant_id  output  2  index of the current or last granted client.
REQ-015 Port: round_done  output  1  one-cycle pulse when every enabled client has been served once.
REQ-016 Port: timeout_err  output  1  sticky flag set when any grant times out.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, SCAN, ARM, BUSY, RELEASE.
REQ-018 IDLE -> SCAN when enable=1; otherwise the FSM SHALL stay in IDLE.
REQ-019 SCAN SHALL select the next index, round-robin, that is after grant_id and has client_en=1.
  - Selection takes 1 cycle and the FSM goes to ARM.
  - If no bit is enabled, the FSM returns to IDLE.
REQ-020 ARM SHALL hold client_go low until client_done[grant_id]=0, so a client still in its hold is never granted, then go to BUSY.
REQ-021 BUSY SHALL drive client_go[grant_id]=1 until client_done[grant_id]=1, then go to RELEASE.
REQ-022 RELEASE SHALL drop client_go for one cycle.
  - If the just-served index is the last enabled index of the round, pulse round_done.
  - Then go to SCAN if enable=1, else IDLE.
REQ-023 vga_x/vga_y/vga_color SHALL combinationally follow client_*[grant_id].
  - vga_plot = client_plot[grant_id] in BUSY only; it is 0 in every other state.
  - Zero-cycle latency.
REQ-024 client_go SHALL be one-hot or zero at all times; two bits are never high together.
REQ-025 The watchdog counter SHALL be 26-bit and cleared on entry to ARM.
  - It increments in ARM and BUSY.
  - On reaching TIMEOUT: set timeout_err, drop go, go to RELEASE. The client is treated as served.
REQ-026 Clearing client_en[grant_id] during ARM/BUSY SHALL abort to RELEASE on the next cycle.
REQ-027 Dropping enable mid-grant SHALL NOT abort; the current client finishes, then IDLE.
REQ-028 Round-robin wrap: index NUM_CLIENTS-1 SHALL be followed by 0.
REQ-029 Any client_plot from a non-granted client SHALL be ignored.

Reset
REQ-030 reset=1 SHALL, at the next edge, force the following, overriding every other condition:
  - state IDLE
  - grant_id = NUM_CLIENTS-1, so the first grant goes to client 0
  - client_go = 0, round_done = 0, timeout_err = 0, watchdog = 0
REQ-031 While reset is high, vga_plot SHALL be 0.
REQ-032 Reset asserted during BUSY SHALL deassert client_go in the same edge.

Structure
REQ-033 The shared game package SHALL hold the state encodings, client index constants (BALL0=0, BALL1=1, PAD_BOT=2, PAD_TOP=3) and the TIMEOUT default.
REQ-034 One sub-module SHALL be used: rr_select.
  - Combinational next-enabled-index finder.
  - Inputs: mask, last; outputs: next, valid.

Verification
REQ-035 Enable all 4 clients, each model raises done 20 cycles after go -> go order 0,1,2,3,0; round_done pulses once after client 3.
REQ-036 client_done[1] held high for 50 cycles when client 1 is selected -> go[1] stays low in ARM for 50 cycles, then rises.
REQ-037 client_en=4'b0101 -> grants alternate 0,2,0,2; clients 1 and 3 never see go.
REQ-038 Client 2 never raises done, TIMEOUT=100 -> go[2] drops after 100 cycles, timeout_err=1, next grant goes to 3.
REQ-039 Client 0 drives plot with x=8'd70, y=7'd50, color=3'b101 during BUSY while client 1 also plots -> vga outputs equal client 0 values only.
REQ-040 Assert reset in BUSY of client 2 -> next cycle: go=0, vga_plot=0, state IDLE; after release the first grant goes to client 0.

Source files
------------

// File: rtl/draw_arbiter_pkg.sv
// Shared game definitions for the drawing arbiter: FSM states, client indices
// and the default grant watchdog limit.
package draw_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        ARM     = 3'd2,
        BUSY    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int GRANT_W = 2;

    localparam logic [GRANT_W-1:0] BALL0   = 2'd0;
    localparam logic [GRANT_W-1:0] BALL1   = 2'd1;
    localparam logic [GRANT_W-1:0] PAD_BOT = 2'd2;
    localparam logic [GRANT_W-1:0] PAD_TOP = 2'd3;

    localparam logic [25:0] TIMEOUT_DEFAULT = 26'd4000000;

endpackage

// File: rtl/draw_arbiter_rr_select.sv
// Combinational round-robin finder: first set bit of mask strictly after 'last',
// wrapping around, with 'last' itself considered only as the final candidate.
module rr_select
    import draw_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       mask,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] next,
    output logic               valid
);

    // Walk candidates from farthest to nearest so the nearest enabled index wins.
    always_comb begin
        int idx;
        idx   = 0;
        next  = 2'd0;
        valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (mask[idx]) begin
                next  = GRANT_W'(idx);
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates the shared VGA pixel-write port among the drawing clients
// (two balls, two paddles) in round-robin order with a per-grant watchdog.
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter int          NUM_CLIENTS = 4,
    parameter logic [25:0] TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_CLIENTS-1:0]     client_en,
    input  logic [NUM_CLIENTS-1:0]     client_done,
    input  logic [NUM_CLIENTS-1:0]     client_plot,
    input  logic [8*NUM_CLIENTS-1:0]   client_x,
    input  logic [7*NUM_CLIENTS-1:0]   client_y,
    input  logic [3*NUM_CLIENTS-1:0]   client_color,
    output logic [NUM_CLIENTS-1:0]     client_go,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [2:0]                 vga_color,
    output logic                       vga_plot,
    output logic [GRANT_W-1:0]         grant_id,
    output logic                       round_done,
    output logic                       timeout_err
);

    state_t                   state_q, state_d;
    logic [GRANT_W-1:0]       grant_id_q, grant_id_d;
    logic [NUM_CLIENTS-1:0]   go_q, go_d;
    logic                     round_done_q, round_done_d;
    logic                     timeout_err_q, timeout_err_d;
    logic [25:0]              wd_q, wd_d;

    logic [GRANT_W-1:0]       rr_next_s;
    logic                     rr_valid_s;
    logic [GRANT_W-1:0]       last_en_s;
    logic [25:0]              wd_inc_s;
    logic [NUM_CLIENTS-1:0]   grant_onehot_s;
    int unsigned              gi_s;

    rr_select #(.N(NUM_CLIENTS)) u_rr_select (
        .mask  (client_en),
        .last  (grant_id_q),
        .next  (rr_next_s),
        .valid (rr_valid_s)
    );

    // Highest enabled index closes a round.
    always_comb begin
        last_en_s = 2'd0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (client_en[i]) begin
                last_en_s = GRANT_W'(i);
            end else begin
                last_en_s = last_en_s;
            end
        end
    end

    assign wd_inc_s       = wd_q + 26'd1;
    assign grant_onehot_s = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << grant_id_q;
    assign gi_s           = 32'(grant_id_q);

    // Next-state logic; go_d is set only while the grant stays in BUSY.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        go_d          = '0;
        round_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        wd_d          = wd_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = SCAN;
                else        state_d = IDLE;
            end
            SCAN: begin
                if (rr_valid_s) begin
                    grant_id_d = rr_next_s;
                    wd_d       = 26'd0;
                    state_d    = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                wd_d = wd_inc_s;
                if (!client_en[grant_id_q]) begin
                    state_d = RELEASE;
                end else if (wd_inc_s == TIMEOUT) begin
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end else if (!client_done[grant_id_q]) begin
                    go_d    = grant_onehot_s;
                    state_d = BUSY;
                end else begin
                    state_d = ARM;
                end
            end
            BUSY: begin
                wd_d = wd_inc_s;
                if (!client_en[grant_id_q]) begin
                    state_d = RELEASE;
                end else if (wd_inc_s == TIMEOUT) begin
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end else if (client_done[grant_id_q]) begin
                    state_d = RELEASE;
                end else begin
                    go_d    = grant_onehot_s;
                    state_d = BUSY;
                end
            end
            RELEASE: begin
                round_done_d = (|client_en) && (grant_id_q == last_en_s);
                if (enable) state_d = SCAN;
                else        state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_id_q    <= GRANT_W'(NUM_CLIENTS-1);
            go_q          <= '0;
            round_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= 26'd0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            go_q          <= go_d;
            round_done_q  <= round_done_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

    // Zero-latency pixel mux; only the granted client in BUSY may write.
    always_comb begin
        vga_x     = client_x[8*gi_s +: 8];
        vga_y     = client_y[7*gi_s +: 7];
        vga_color = client_color[3*gi_s +: 3];
        if (!reset && (state_q == BUSY)) begin
            vga_plot = client_plot[grant_id_q];
        end else begin
            vga_plot = 1'b0;
        end
    end

    assign client_go   = go_q;
    assign grant_id    = grant_id_q;
    assign round_done  = round_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized self-checking bench for draw_arbiter with behavioural client
// models and a round-robin grant-order reference.
module tb_draw_arbiter;
    import draw_arbiter_pkg::*;

    localparam int          N    = 4;
    localparam logic [25:0] TO   = 26'd100;
    localparam int          DLY  = 20;
    localparam int          HOLD = 3;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [3:0]  client_en, client_done, client_plot, client_go;
    logic [31:0] client_x;
    logic [27:0] client_y;
    logic [11:0] client_color;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_plot, round_done, timeout_err;
    logic [1:0]  grant_id;

    always #5 clk = ~clk;

    draw_arbiter #(.NUM_CLIENTS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .client_en(client_en), .client_done(client_done), .client_plot(client_plot),
        .client_x(client_x), .client_y(client_y), .client_color(client_color),
        .client_go(client_go), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .vga_plot(vga_plot), .grant_id(grant_id), .round_done(round_done),
        .timeout_err(timeout_err)
    );

    int         n_cmp = 0, n_bad = 0;
    int         cnt[4], hold[4], go_len[4], last_len[4];
    logic [3:0] dn, force_done, stuck, prev_go, seen_go;
    int         grants[$];
    int         exp_last, rd_cnt;
    logic       rand_io;

    function automatic int rr_next(input int last, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            if (m[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int top_en(input logic [3:0] m);
        int t = -1;
        for (int i = 0; i < 4; i++) if (m[i]) t = i;
        return t;
    endfunction

    // One clock: observe DUT after the edge, check against the model, then drive clients.
    task automatic step();
        int e, g;
        @(posedge clk);
        #1;
        if (!reset) begin
            n_cmp++;
            if ($countones(client_go) > 1) begin
                n_bad++; $display("FAIL onehot: go=%b required at most one bit", client_go);
            end
            if (client_go != 4'd0 && prev_go == 4'd0) begin
                e = rr_next(exp_last, client_en);
                g = 0;
                for (int i = 0; i < 4; i++) if (client_go[i]) g = i;
                grants.push_back(g);
                n_cmp++;
                if (g != e) begin
                    n_bad++; $display("FAIL grant_order: got client %0d required %0d", g, e);
                end
                exp_last = (e < 0) ? 0 : e;
            end
            n_cmp++;
            if (client_go != 4'd0) begin
                if (vga_x !== client_x[8*exp_last +: 8] || vga_y !== client_y[7*exp_last +: 7] ||
                    vga_color !== client_color[3*exp_last +: 3] || vga_plot !== client_plot[exp_last]) begin
                    n_bad++;
                    $display("FAIL vga_mux: x=%0d y=%0d c=%0d p=%b required x=%0d y=%0d c=%0d p=%b",
                             vga_x, vga_y, vga_color, vga_plot, client_x[8*exp_last +: 8],
                             client_y[7*exp_last +: 7], client_color[3*exp_last +: 3], client_plot[exp_last]);
                end
            end else if (vga_plot !== 1'b0) begin
                n_bad++; $display("FAIL vga_plot_idle: got %b required 0", vga_plot);
            end
            if (round_done === 1'b1) begin
                rd_cnt++;
                n_cmp++;
                if (exp_last != top_en(client_en)) begin
                    n_bad++; $display("FAIL round_done_pos: after client %0d required %0d", exp_last, top_en(client_en));
                end
            end
        end else begin
            n_cmp++;
            if (vga_plot !== 1'b0) begin
                n_bad++; $display("FAIL vga_plot_reset: got %b required 0", vga_plot);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (client_go[i]) go_len[i]++;
            else if (prev_go[i]) begin last_len[i] = go_len[i]; go_len[i] = 0; end
        end
        seen_go |= client_go;
        prev_go = client_go;
        for (int i = 0; i < 4; i++) begin
            if (client_go[i]) begin
                if (!stuck[i]) begin
                    cnt[i]++;
                    if (cnt[i] >= DLY) begin dn[i] = 1'b1; hold[i] = HOLD; end
                end
            end else begin
                cnt[i] = 0;
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) dn[i] = 1'b0;
                end
            end
        end
        client_done = dn | force_done;
        if (rand_io) begin
            client_x     = $urandom;
            client_y     = 28'($urandom);
            client_color = 12'($urandom);
            client_plot  = 4'($urandom);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; hold[i] = 0; go_len[i] = 0; last_len[i] = 0; end
        dn = 4'd0; force_done = 4'd0; stuck = 4'd0; seen_go = 4'd0;
        client_done = 4'd0;
        grants.delete();
        exp_last = N - 1; rd_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; client_en = 4'hF;
        clear_model();
        step(); step();
        clear_model();
        prev_go = 4'd0;
        reset = 1'b0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int b = 0;
        while (grants.size() < n && b < budget) begin step(); b++; end
        n_cmp++;
        if (grants.size() < n) begin
            n_bad++; $display("FAIL wait_grants: got %0d grants required %0d", grants.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (client_go !== 4'd0 || grant_id !== 2'd3 || round_done !== 1'b0 ||
            timeout_err !== 1'b0 || vga_plot !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: go=%b gid=%0d rd=%b te=%b vp=%b required 0000 3 0 0 0",
                     client_go, grant_id, round_done, timeout_err, vga_plot);
        end
    endtask

    task automatic test_round_robin();
        int expq[$] = '{0, 1, 2, 3, 0};
        do_reset();
        enable = 1'b1;
        wait_grants(5, 2000);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            n_cmp++;
            if (grants[i] != expq[i]) begin
                n_bad++; $display("FAIL rr_seq[%0d]: got %0d required %0d", i, grants[i], expq[i]);
            end
        end
        n_cmp++;
        if (rd_cnt != 1) begin
            n_bad++; $display("FAIL rr_round_done: got %0d pulses required 1", rd_cnt);
        end
    endtask

    task automatic test_hold();
        int b = 0, low = 0;
        do_reset();
        enable = 1'b1;
        force_done = 4'b0010;
        client_done = force_done;
        while (!(grants.size() >= 1 && grant_id == 2'd1 && client_go == 4'd0) && b < 300) begin
            step(); b++;
        end
        repeat (50) begin
            step();
            if (!client_go[1]) low++;
        end
        n_cmp++;
        if (low != 50) begin
            n_bad++; $display("FAIL hold_arm: go[1] low %0d cycles required 50", low);
        end
        force_done = 4'd0;
        b = 0;
        while (!client_go[1] && b < 5) begin step(); b++; end
        n_cmp++;
        if (client_go !== 4'b0010) begin
            n_bad++; $display("FAIL hold_release: go=%b required 0010", client_go);
        end
    endtask

    task automatic test_mask();
        int expq[$] = '{0, 2, 0, 2};
        do_reset();
        client_en = 4'b0101;
        enable = 1'b1;
        wait_grants(4, 2000);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            n_cmp++;
            if (grants[i] != expq[i]) begin
                n_bad++; $display("FAIL mask_seq[%0d]: got %0d required %0d", i, grants[i], expq[i]);
            end
        end
        n_cmp++;
        if ((seen_go & 4'b1010) != 4'd0 || rd_cnt != 1) begin
            n_bad++; $display("FAIL mask_excluded: seen=%b rd=%0d required seen&1010=0 rd=1", seen_go, rd_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        stuck = 4'b0100;
        enable = 1'b1;
        wait_grants(3, 2000);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL timeout_early: got %b required 0", timeout_err);
        end
        wait_grants(4, 2000);
        n_cmp++;
        // go rises one cycle after the watchdog starts counting in ARM
        if (last_len[2] != int'(TO) - 1) begin
            n_bad++; $display("FAIL timeout_len: go[2] high %0d required %0d", last_len[2], int'(TO) - 1);
        end
        n_cmp++;
        if (timeout_err !== 1'b1 || grants.size() < 4 || grants[3] != 3) begin
            n_bad++; $display("FAIL timeout_next: te=%b next=%0d required te=1 next=3",
                              timeout_err, (grants.size() >= 4) ? grants[3] : -1);
        end
    endtask

    task automatic test_plot_mux();
        do_reset();
        rand_io = 1'b0;
        client_x = 32'd0; client_y = 28'd0; client_color = 12'd0;
        client_x[7:0] = 8'd70;  client_y[6:0]  = 7'd50; client_color[2:0] = 3'b101;
        client_x[15:8] = 8'd200; client_y[13:7] = 7'd99; client_color[5:3] = 3'b010;
        client_plot = 4'b0011;
        enable = 1'b1;
        wait_grants(1, 100);
        step();
        n_cmp++;
        if (vga_x !== 8'd70 || vga_y !== 7'd50 || vga_color !== 3'b101 || vga_plot !== 1'b1) begin
            n_bad++; $display("FAIL plot_mux: x=%0d y=%0d c=%b p=%b required 70 50 101 1",
                              vga_x, vga_y, vga_color, vga_plot);
        end
        rand_io = 1'b1;
    endtask

    task automatic test_reset_busy();
        do_reset();
        enable = 1'b1;
        wait_grants(3, 2000);
        step();
        reset = 1'b1;
        step();
        n_cmp++;
        if (client_go !== 4'd0 || vga_plot !== 1'b0 || grant_id !== 2'd3) begin
            n_bad++; $display("FAIL reset_busy: go=%b vp=%b gid=%0d required 0000 0 3", client_go, vga_plot, grant_id);
        end
        clear_model();
        reset = 1'b0;
        wait_grants(1, 100);
        n_cmp++;
        if (grants.size() < 1 || grants[0] != 0) begin
            n_bad++; $display("FAIL reset_first: got %0d required 0", (grants.size() > 0) ? grants[0] : -1);
        end
    endtask

    task automatic test_enable_drop();
        int b = 0;
        do_reset();
        enable = 1'b1;
        wait_grants(1, 100);
        enable = 1'b0;
        while (client_go != 4'd0 && b < 100) begin step(); b++; end
        repeat (40) step();
        n_cmp++;
        if (last_len[0] != DLY || grants.size() != 1 || client_go !== 4'd0) begin
            n_bad++; $display("FAIL enable_drop: len=%0d grants=%0d go=%b required %0d 1 0000",
                              last_len[0], grants.size(), client_go, DLY);
        end
    endtask

    task automatic test_en_abort();
        do_reset();
        enable = 1'b1;
        wait_grants(2, 200);
        repeat (3) step();
        client_en = 4'b1101;
        step();
        n_cmp++;
        if (client_go !== 4'd0) begin
            n_bad++; $display("FAIL en_abort: go=%b required 0000", client_go);
        end
        wait_grants(3, 200);
        n_cmp++;
        if (grants.size() < 3 || grants[2] != 2 || last_len[1] >= DLY) begin
            n_bad++; $display("FAIL en_abort_next: next=%0d len=%0d required next=2 len<%0d",
                              (grants.size() >= 3) ? grants[2] : -1, last_len[1], DLY);
        end
    endtask

    initial begin
        rand_io = 1'b1;
        reset = 1'b1; enable = 1'b0; client_en = 4'hF; client_plot = 4'd0;
        client_x = 32'd0; client_y = 28'd0; client_color = 12'd0;
        prev_go = 4'd0;
        clear_model();
        test_reset();
        test_round_robin();
        test_hold();
        test_mask();
        test_timeout();
        test_plot_mux();
        test_reset_busy();
        test_enable_drop();
        test_en_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
